// File: rtl/divider_control.sv
// Sequencing FSM for a shift-subtract restoring divider: Start -> load, shift, WIDTH iterations, fixup, done.
// Optional divide-by-zero short-circuit enabled by defining DIV_ZERO_DETECT_EN.
module divider_control #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Divisor_zero,
   output logic             W_ctrl,
   output logic             SLL_ctrl,
   output logic             SRL_ctrl,
   output logic             ALU_sub,
   output logic             Busy,
   output logic             Ready,
   output logic [CNT_W-1:0] Iter_count,
   output logic             Div_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SHIFT0, S_ITER, S_FIXUP, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WIDTH-1);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_accept;
   logic             w_zero;

`ifdef DIV_ZERO_DETECT_EN
   assign w_zero = Divisor_zero;
`else
   logic w_unused_dz;
   assign w_unused_dz = Divisor_zero;
   assign w_zero      = 1'b0;
`endif

   // Start only counts when no operation is in flight
   assign w_accept = Start && (r_state == S_IDLE || r_state == S_DONE);

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cnt <= '0;
            r_err <= w_zero;
         end else if (r_state == S_ITER) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next   = r_state;
      W_ctrl   = 1'b0;
      SLL_ctrl = 1'b0;
      SRL_ctrl = 1'b0;
      ALU_sub  = 1'b0;
      Busy     = 1'b0;
      Ready    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = w_zero ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            W_ctrl = 1'b1;
            Busy   = 1'b1;
            w_next = S_SHIFT0;
         end
         S_SHIFT0: begin
            SLL_ctrl = 1'b1;
            Busy     = 1'b1;
            w_next   = S_ITER;
         end
         S_ITER: begin
            SLL_ctrl = 1'b1;
            ALU_sub  = 1'b1;
            Busy     = 1'b1;
            // counter increments on this edge, reaching WIDTH as FIXUP begins
            if (r_cnt == LAST_M1) w_next = S_FIXUP;
         end
         S_FIXUP: begin
            SRL_ctrl = 1'b1;
            Busy     = 1'b1;
            w_next   = S_DONE;
         end
         S_DONE: begin
            Ready = 1'b1;
            if (w_accept) w_next = w_zero ? S_DONE : S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign Iter_count = r_cnt;
   assign Div_err    = r_err;

endmodule
